stream_demux1_2: RTL and testbench
==================================

Name: stream_demux1_2

Overview:
- Splitting counterpart of the 2:1 mux: routes one valid/ready input stream to one of two output streams, A or B.
- Routing is chosen per packet. IN_SEL is sampled on the first beat only; the route holds until the beat with IN_LAST is accepted.
- Each output has one register slice, so every output is registered and one beat per cycle is sustained.
- Sits between a single producer and two downstream consumers. It also counts packets delivered to each output.

Parameters:
- WIDTH, 8, data width of every beat.
- CNT_W, 8, width of each per-output packet counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_DATA  input  WIDTH  input beat payload.
- IN_SEL  input  1  route select (0=A, 1=B); valid only on the first beat of a packet.
- IN_LAST  input  1  marks the final beat of a packet.
- IN_VALID  input  1  input beat present.
- IN_READY  output  1  input beat accepted this cycle when high together with IN_VALID.
- A_DATA  output  WIDTH  output A payload.
- A_LAST  output  1  output A last-beat flag.
- A_VALID  output  1  output A beat present.
- A_READY  input  1  downstream A accepts.
- B_DATA  output  WIDTH  output B payload.
- B_LAST  output  1  output B last-beat flag.
- B_VALID  output  1  output B beat present.
- B_READY  input  1  downstream B accepts.
- A_PKTS  output  CNT_W  count of packets accepted into A; wraps.
- B_PKTS  output  CNT_W  count of packets accepted into B; wraps.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = IDLE.
  - A_VALID = B_VALID = 0.
  - A_DATA, B_DATA, A_LAST, B_LAST = 0.
  - A_PKTS = B_PKTS = 0.
  - Reset mid-packet discards buffered beats and the route lock; the next accepted beat is treated as a first beat.
- States:
  - IDLE: no packet open; the target is IN_SEL.
  - LOCK_A: packet open, target A.
  - LOCK_B: packet open, target B.
- Transitions, applied only when IN_VALID and IN_READY are both high:
  - IDLE with IN_LAST=0 -> LOCK_A if IN_SEL=0, LOCK_B if IN_SEL=1.
  - IDLE with IN_LAST=1 -> stays IDLE (single-beat packet).
  - LOCK_x with IN_LAST=1 -> IDLE.
  - LOCK_x with IN_LAST=0 -> stays LOCK_x.
  - In LOCK_x, IN_SEL is ignored.
- Slice rules:
  - Slice x can accept when x_VALID=0 or x_READY=1.
  - IN_READY = can-accept of the current target slice.
  - IN_READY is combinational from state, IN_SEL and the target x_READY. It does not depend on IN_VALID.
  - IN_READY ignores the non-target slice entirely: a stalled B never blocks a packet bound for A.
- Accepted beat:
  - Loaded into the target slice (DATA, LAST, VALID=1) on the same edge.
  - Latency 1 cycle: the beat appears on x_DATA in the cycle after acceptance.
- Slice output:
  - x_VALID clears when x_READY=1 and no new beat is loaded that edge.
  - Simultaneous drain and load keeps VALID=1 with the new payload, giving full throughput.
  - x_DATA and x_LAST are held stable while x_VALID=1 and x_READY=0.
- Packet counters:
  - x_PKTS increments by 1 on acceptance of a beat with IN_LAST=1 whose target is x.
  - Modulo 2^CNT_W: 255 -> 0 at the default width.
- Only one output is targeted per cycle, so the two counters never increment in the same cycle.

Decomposition:
- Package stream_demux_pkg holds:
  - typedef enum demux_state_e {IDLE, LOCK_A, LOCK_B};
  - constants SEL_A=1'b0 and SEL_B=1'b1.
- Sub-module stream_reg_slice (parameter WIDTH+1 bits to carry data plus last):
  - one-entry valid/ready register slice;
  - instantiated twice, once per output.
- Top level holds the state machine, ready steering and the counters.

Test Plan:
- Single beat to A:
  - Stimulus: IN_DATA=8'h5A, IN_SEL=0, IN_LAST=1, A_READY=1.
  - Response: next cycle A_VALID=1, A_DATA=8'h5A, A_LAST=1; B_VALID stays 0; A_PKTS=1; state IDLE.
- 3-beat packet to B, IN_SEL toggled on beats 2–3:
  - Stimulus: beats 8'h11, 8'h22, 8'h33 with IN_SEL=1 on beat 1.
  - Response: all three beats appear on B in order; only beat 3 has B_LAST=1; A_VALID stays 0; B_PKTS=1.
- Backpressure isolation:
  - Stimulus: A_READY=0 while A holds a beat; B_READY=1; present a first beat with IN_SEL=0, then one with IN_SEL=1.
  - Response: IN_READY=0 for the A-bound beat and A_DATA stays stable; after the A-bound beat is withdrawn and the B-bound beat presented, IN_READY=1 and the B beat is accepted.
- Throughput:
  - Stimulus: 10 back-to-back beats to A with A_READY=1 throughout.
  - Response: one beat out per cycle, no bubbles, data matches input in order.
- Counter wrap:
  - Stimulus: 256 single-beat packets to A.
  - Response: A_PKTS goes 255 -> 0; B_PKTS stays 0.
- Reset mid-packet:
  - Stimulus: assert RST_N=0 after beat 1 of a packet to B.
  - Response: immediately B_VALID=0 and counters 0; after release, a beat with IN_SEL=0 routes to A.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the 1:2 stream demultiplexer.
package stream_demux_pkg;

    // Route-lock state: IDLE means no packet is open and IN_SEL picks the target.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } demux_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : stream_demux_pkg

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register slice. The parent only pulses 'load' when
// 'can_accept' is high, so a loaded beat never overwrites an undelivered one.
module stream_reg_slice #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] load_data,
    input  logic         load,
    output logic         can_accept,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [W-1:0] data_r;
    logic         valid_r;

    // Slot is free when empty or when its current beat drains this edge.
    always_comb begin
        can_accept = (~valid_r) | out_ready;
    end

    // Load wins over drain, keeping VALID high for back-to-back beats; payload
    // only changes on a load, so it stays stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {W{1'b0}};
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= load_data;
            valid_r <= 1'b1;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign out_data  = data_r;
    assign out_valid = valid_r;

endmodule : stream_reg_slice

// File: rtl/stream_demux1_2.sv
// 1:2 packet demultiplexer: routes each packet to output A or B based on the
// select seen on its first beat, with a register slice per output and
// wrapping per-output packet counters.
module stream_demux1_2 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_last,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_last,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_pkts,
    output logic [CNT_W-1:0] b_pkts
);

    import stream_demux_pkg::*;

    demux_state_e     state_r;
    demux_state_e     state_nxt_s;
    logic             target_s;
    logic             accept_s;
    logic             a_can_s;
    logic             b_can_s;
    logic             a_load_s;
    logic             b_load_s;
    logic [WIDTH:0]   a_slot_s;
    logic [WIDTH:0]   b_slot_s;
    logic [CNT_W-1:0] a_pkts_r;
    logic [CNT_W-1:0] b_pkts_r;

    // Target output: live select between packets, locked route inside one.
    always_comb begin
        target_s = in_sel;
        case (state_r)
            IDLE:    target_s = in_sel;
            LOCK_A:  target_s = SEL_A;
            LOCK_B:  target_s = SEL_B;
            default: target_s = in_sel;
        endcase
    end

    // Ready follows only the target slice so a stalled peer never blocks us.
    always_comb begin
        if (target_s == SEL_B) begin
            in_ready = b_can_s;
        end else begin
            in_ready = a_can_s;
        end
    end

    // Handshake and per-slice load strobes.
    always_comb begin
        accept_s = in_valid & in_ready;
        a_load_s = accept_s & (target_s == SEL_A);
        b_load_s = accept_s & (target_s == SEL_B);
    end

    // Next-state: open a lock on a non-last first beat, release it on last.
    always_comb begin
        state_nxt_s = state_r;
        if (accept_s) begin
            case (state_r)
                IDLE: begin
                    if (in_last) begin
                        state_nxt_s = IDLE;
                    end else if (in_sel == SEL_B) begin
                        state_nxt_s = LOCK_B;
                    end else begin
                        state_nxt_s = LOCK_A;
                    end
                end
                LOCK_A: begin
                    if (in_last) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = LOCK_A;
                    end
                end
                LOCK_B: begin
                    if (in_last) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = LOCK_B;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Route-lock state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Packet counters advance when a last beat is accepted for their output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_pkts_r <= {CNT_W{1'b0}};
            b_pkts_r <= {CNT_W{1'b0}};
        end else begin
            if (a_load_s && in_last) begin
                a_pkts_r <= a_pkts_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (b_load_s && in_last) begin
                b_pkts_r <= b_pkts_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    stream_reg_slice #(.W(WIDTH + 1)) u_slice_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_data  ({in_last, in_data}),
        .load       (a_load_s),
        .can_accept (a_can_s),
        .out_data   (a_slot_s),
        .out_valid  (a_valid),
        .out_ready  (a_ready)
    );

    stream_reg_slice #(.W(WIDTH + 1)) u_slice_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_data  ({in_last, in_data}),
        .load       (b_load_s),
        .can_accept (b_can_s),
        .out_data   (b_slot_s),
        .out_valid  (b_valid),
        .out_ready  (b_ready)
    );

    assign a_data = a_slot_s[WIDTH-1:0];
    assign a_last = a_slot_s[WIDTH];
    assign b_data = b_slot_s[WIDTH-1:0];
    assign b_last = b_slot_s[WIDTH];
    assign a_pkts = a_pkts_r;
    assign b_pkts = b_pkts_r;

endmodule : stream_demux1_2

// File: tb/tb_stream_demux1_2.sv
// Self-checking bench for stream_demux1_2: directed scenarios plus a random
// run, all checked against a packet-level queue model.
module tb_stream_demux1_2;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_data;
    logic       a_last;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_last;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] a_pkts;
    logic [7:0] b_pkts;

    int vectors;
    int miscompares;

    // Reference model: each output is a queue of {last,data} beats awaiting
    // delivery; a packet is "open" between its first and last accepted beat.
    logic [8:0] a_q[$];
    logic [8:0] b_q[$];
    bit         m_open;
    bit         m_route;
    logic [7:0] m_a_cnt;
    logic [7:0] m_b_cnt;

    stream_demux1_2 #(.WIDTH(8), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_last   (a_last),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_last   (b_last),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_pkts   (a_pkts),
        .b_pkts   (b_pkts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_target();
        return m_open ? m_route : in_sel;
    endfunction

    function automatic bit m_ready();
        if (m_target()) return (b_q.size() == 0) || b_ready;
        return (a_q.size() == 0) || a_ready;
    endfunction

    function automatic void m_clear();
        a_q.delete();
        b_q.delete();
        m_open  = 1'b0;
        m_route = 1'b0;
        m_a_cnt = 8'd0;
        m_b_cnt = 8'd0;
    endfunction

    task automatic drive(input logic v, input logic s, input logic l,
                         input logic [7:0] d, input logic ar, input logic br);
        in_valid = v;
        in_sel   = s;
        in_last  = l;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
    endtask

    // Advance one clock edge and the model with it; called just after drive.
    task automatic tick();
        bit         t;
        bit         acc;
        logic [8:0] beat;
        t    = m_target();
        acc  = in_valid && m_ready();
        beat = {in_last, in_data};
        if (a_q.size() != 0 && a_ready) void'(a_q.pop_front());
        if (b_q.size() != 0 && b_ready) void'(b_q.pop_front());
        if (acc) begin
            if (t) b_q.push_back(beat);
            else   a_q.push_back(beat);
            if (beat[8]) begin
                m_open = 1'b0;
                if (t) m_b_cnt = m_b_cnt + 8'd1;
                else   m_a_cnt = m_a_cnt + 8'd1;
            end else begin
                m_open  = 1'b1;
                m_route = t;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        m_clear();
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({a_valid, b_valid, a_last, b_last} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags got %b%b%b%b want 0000", a_valid, b_valid, a_last, b_last);
        end
        vectors++;
        if ({a_data, b_data, a_pkts, b_pkts} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_regs got %h want 00000000", {a_data, b_data, a_pkts, b_pkts});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_a();
        drive(1'b1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_a_ready got %b want 1", in_ready);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        vectors++;
        if ({a_valid, a_last, a_data, b_valid} !== {1'b1, 1'b1, 8'h5A, 1'b0}) begin
            miscompares++;
            $display("FAIL single_a_out got v=%b l=%b d=%h bv=%b want v=1 l=1 d=5a bv=0",
                     a_valid, a_last, a_data, b_valid);
        end
        vectors++;
        if (a_pkts !== 8'd1 || b_pkts !== 8'd0) begin
            miscompares++;
            $display("FAIL single_a_pkts got a=%0d b=%0d want a=1 b=0", a_pkts, b_pkts);
        end
        a_ready = 1'b1;
        #1;
        tick();
    endtask

    task automatic test_pkt_b();
        logic [7:0] d[3];
        logic       s[3];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
        s[0] = 1'b1;  s[1] = 1'b0;  s[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, s[i], (i == 2), d[i], 1'b1, 1'b1);
            tick();
            vectors++;
            if ({b_valid, b_last, b_data, a_valid} !== {1'b1, (i == 2), d[i], 1'b0}) begin
                miscompares++;
                $display("FAIL pkt_b_beat%0d got bv=%b bl=%b bd=%h av=%b want bv=1 bl=%b bd=%h av=0",
                         i, b_valid, b_last, b_data, a_valid, (i == 2), d[i]);
            end
        end
        vectors++;
        if (b_pkts !== m_b_cnt || m_b_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL pkt_b_count got %0d want 1", b_pkts);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'h88, 1'b0, 1'b1);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_a_ready got %b want 0", in_ready);
        end
        tick();
        vectors++;
        if (a_valid !== 1'b1 || a_data !== 8'h77) begin
            miscompares++;
            $display("FAIL bp_a_hold got v=%b d=%h want v=1 d=77", a_valid, a_data);
        end
        drive(1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b1);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_b_ready got %b want 1", in_ready);
        end
        tick();
        vectors++;
        if ({b_valid, b_data, a_valid, a_data} !== {1'b1, 8'h99, 1'b1, 8'h77}) begin
            miscompares++;
            $display("FAIL bp_b_beat got bv=%b bd=%h av=%b ad=%h want bv=1 bd=99 av=1 ad=77",
                     b_valid, b_data, a_valid, a_data);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        tick();
    endtask

    task automatic test_throughput();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, (i == 9), 8'hA0 + 8'(i), 1'b1, 1'b0);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL thru_ready%0d got %b want 1", i, in_ready);
            end
            tick();
            vectors++;
            if (a_valid !== 1'b1 || a_data !== 8'hA0 + 8'(i)) begin
                miscompares++;
                $display("FAIL thru_beat%0d got v=%b d=%h want v=1 d=%h",
                         i, a_valid, a_data, 8'hA0 + 8'(i));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_counter_wrap();
        logic [7:0] prev;
        logic [7:0] b_start;
        bit         wrapped;
        wrapped = 1'b0;
        b_start = b_pkts;
        prev    = a_pkts;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(i), 1'b1, 1'b1);
            tick();
            vectors++;
            if (a_pkts !== m_a_cnt) begin
                miscompares++;
                $display("FAIL wrap_a_pkts%0d got %0d want %0d", i, a_pkts, m_a_cnt);
            end
            if (prev == 8'd255 && a_pkts == 8'd0) wrapped = 1'b1;
            prev = a_pkts;
        end
        vectors++;
        if (!wrapped || b_pkts !== b_start) begin
            miscompares++;
            $display("FAIL wrap_summary got wrapped=%b b=%0d want wrapped=1 b=%0d",
                     wrapped, b_pkts, b_start);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), 8'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
            vectors++;
            if (in_ready !== m_ready()) begin
                miscompares++;
                $display("FAIL rand_ready c%0d got %b want %b", c, in_ready, m_ready());
            end
            tick();
            vectors++;
            if (a_valid !== (a_q.size() != 0) || b_valid !== (b_q.size() != 0)) begin
                miscompares++;
                $display("FAIL rand_valid c%0d got a=%b b=%b want a=%b b=%b",
                         c, a_valid, b_valid, (a_q.size() != 0), (b_q.size() != 0));
            end
            if (a_q.size() != 0) begin
                vectors++;
                if ({a_last, a_data} !== a_q[0]) begin
                    miscompares++;
                    $display("FAIL rand_a_beat c%0d got %h want %h", c, {a_last, a_data}, a_q[0]);
                end
            end
            if (b_q.size() != 0) begin
                vectors++;
                if ({b_last, b_data} !== b_q[0]) begin
                    miscompares++;
                    $display("FAIL rand_b_beat c%0d got %h want %h", c, {b_last, b_data}, b_q[0]);
                end
            end
            vectors++;
            if (a_pkts !== m_a_cnt || b_pkts !== m_b_cnt) begin
                miscompares++;
                $display("FAIL rand_pkts c%0d got a=%0d b=%0d want a=%0d b=%0d",
                         c, a_pkts, b_pkts, m_a_cnt, m_b_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0);
        tick();
        vectors++;
        if (b_valid !== 1'b1 || b_data !== 8'hC3) begin
            miscompares++;
            $display("FAIL rmid_first got v=%b d=%h want v=1 d=c3", b_valid, b_data);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        m_clear();
        vectors++;
        if (b_valid !== 1'b0 || a_pkts !== 8'd0 || b_pkts !== 8'd0) begin
            miscompares++;
            $display("FAIL rmid_reset got bv=%b a=%0d b=%0d want bv=0 a=0 b=0",
                     b_valid, a_pkts, b_pkts);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'hE1, 1'b1, 1'b1);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_ready got %b want 1", in_ready);
        end
        tick();
        vectors++;
        if ({a_valid, a_data, b_valid, a_pkts} !== {1'b1, 8'hE1, 1'b0, 8'd1}) begin
            miscompares++;
            $display("FAIL rmid_route got av=%b ad=%h bv=%b ap=%0d want av=1 ad=e1 bv=0 ap=1",
                     a_valid, a_data, b_valid, a_pkts);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_a();
        test_pkt_b();
        test_backpressure();
        test_throughput();
        test_counter_wrap();
        test_random();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_stream_demux1_2
